// File: rtl/route_request_unit.sv
// Per-input-port sequencer: routes the FIFO head flit to one productive output
// chosen round-robin, requests it from the switch allocator, then drains one packet.
module route_request_unit #(
    parameter int PKT_FLITS = 5,
    parameter int CNT_WIDTH = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fifo_empty_din,
    input  logic [3:0] valid_channels_din,
    input  logic [3:0] port_status_din,
    input  logic       grant_din,
    output logic [3:0] request_vector_dout,
    output logic       fifo_read_dout,
    output logic       xfer_active_dout,
    output logic       route_stall_dout,
    output logic [1:0] debug_state,
    output logic [1:0] debug_rr_ptr
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROUTE   = 2'd1,
        REQUEST = 2'd2,
        XFER    = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_FLIT = CNT_WIDTH'(PKT_FLITS - 1);

    state_t               state_q, state_d;
    logic [3:0]           request_q, request_d;
    logic [1:0]           rr_ptr_q, rr_ptr_d;
    logic [CNT_WIDTH-1:0] flit_cnt_q, flit_cnt_d;

    logic [3:0] cand;
    logic       found;
    logic [1:0] sel_idx;
    logic [1:0] scan_idx;
    logic       pop;
    logic       stall;

    // Round-robin pick: first candidate at or after rr_ptr, wrapping modulo 4.
    always_comb begin
        cand     = valid_channels_din & port_status_din;
        found    = 1'b0;
        sel_idx  = rr_ptr_q;
        scan_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            scan_idx = rr_ptr_q + 2'(i);
            if (!found && cand[scan_idx]) begin
                found   = 1'b1;
                sel_idx = scan_idx;
            end
        end
    end

    // Handshake: request_vector_dout is held from REQUEST until the tail pop;
    // a flit moves on every XFER cycle with grant_din high and the FIFO non-empty.
    always_comb begin
        state_d    = state_q;
        request_d  = request_q;
        rr_ptr_d   = rr_ptr_q;
        flit_cnt_d = flit_cnt_q;
        pop        = 1'b0;
        stall      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty_din) state_d = ROUTE;
            end
            ROUTE: begin
                if (!found) begin
                    stall = 1'b1;
                end else begin
                    request_d = 4'b0001 << sel_idx;
                    rr_ptr_d  = sel_idx + 2'd1;
                    state_d   = REQUEST;
                end
            end
            REQUEST: begin
                if (grant_din) begin
                    state_d    = XFER;
                    flit_cnt_d = '0;
                end
            end
            XFER: begin
                pop = grant_din & ~fifo_empty_din;
                if (pop) begin
                    if (flit_cnt_q == LAST_FLIT) begin
                        state_d    = IDLE;
                        request_d  = 4'b0000;
                        flit_cnt_d = '0;
                    end else begin
                        flit_cnt_d = flit_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            request_q  <= 4'b0000;
            rr_ptr_q   <= 2'd0;
            flit_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            request_q  <= request_d;
            rr_ptr_q   <= rr_ptr_d;
            flit_cnt_q <= flit_cnt_d;
        end
    end

    assign request_vector_dout = request_q;
    assign fifo_read_dout      = pop;
    assign xfer_active_dout    = (state_q == XFER);
    assign route_stall_dout    = stall;
    assign debug_state         = state_q;
    assign debug_rr_ptr        = rr_ptr_q;

endmodule

// File: doc/route_request_unit.md
Name: route_request_unit

Overview:
- Per-input-port sequencer that sits directly downstream of the routing-algorithm stage inside the link controller.
- Waits for a head flit at the input FIFO output and samples the 4-bit productive-channel mask that the routing stage computes combinationally from that head flit.
- Masks the productive channels with downstream availability and picks one output using round-robin. It then requests that output from the switch allocator and, once granted, drains exactly one fixed-length packet from the FIFO.

Parameters:
PKT_FLITS, 5, flits per packet including the head flit; must be ≥ 2.
CNT_WIDTH, 3, flit counter width; must satisfy 2^CNT_WIDTH ≥ PKT_FLITS.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-low reset.
fifo_empty_din  input  1  input FIFO empty flag; when low, the head of the FIFO is visible at its output.
valid_channels_din  input  4  productive output mask from the routing stage for the current FIFO head.
port_status_din  input  4  per-output availability; 1 = the downstream port can accept a new packet.
grant_din  input  1  switch allocator grant for this unit's current request.
request_vector_dout  output  4  one-hot output-port request (registered).
fifo_read_dout  output  1  FIFO pop strobe; one flit is transferred per cycle it is high.
xfer_active_dout  output  1  high while in XFER.
route_stall_dout  output  1  high during a ROUTE cycle whose candidate set is empty.

Behaviour:
- State machine: IDLE, ROUTE, REQUEST, XFER (2-bit encoding).
- Registers: state, request_vector (4 bits), rr_ptr (2 bits), flit_cnt (CNT_WIDTH bits).
- Reset (reset = 0 at a clock edge, in any state, including mid-packet):
  - state = IDLE, request_vector_dout = 4'b0000, rr_ptr = 0, flit_cnt = 0.
  - Combinational outputs are therefore 0: fifo_read_dout, xfer_active_dout, route_stall_dout.
  - A partially transferred packet is abandoned; no recovery is attempted.
- IDLE:
  - fifo_empty_din = 0 → ROUTE next cycle.
  - Otherwise remain in IDLE.
- ROUTE:
  - cand = valid_channels_din & port_status_din.
  - cand = 0: route_stall_dout = 1; remain in ROUTE and re-evaluate every cycle.
  - cand ≠ 0: select the first set bit of cand scanning indices rr_ptr, rr_ptr+1, … modulo 4.
    - Register its one-hot code into request_vector.
    - Set rr_ptr = selected index + 1 (mod 4).
    - → REQUEST.
  - No flit is popped in ROUTE, so the head flit (and hence valid_channels_din) stays stable.
- REQUEST:
  - request_vector_dout is held constant.
  - grant_din = 1 → XFER with flit_cnt = 0.
  - No timeout.
- XFER:
  - fifo_read_dout = grant_din & ~fifo_empty_din (combinational).
  - Each pop increments flit_cnt.
  - The pop with flit_cnt = PKT_FLITS-1 is the tail pop. On that edge:
    - → IDLE.
    - request_vector = 0.
    - flit_cnt = 0.
  - If grant_din drops, or the FIFO runs empty, the transfer pauses with no pop and no count change. The state and request are held.
  - The request remains asserted throughout XFER to hold the crossbar connection.
- Latencies:
  - FIFO non-empty → request visible: 2 cycles (IDLE → ROUTE → REQUEST, with request_vector_dout high in REQUEST).
  - Grant → first pop: 1 cycle (first pop in the XFER cycle).
  - Back-to-back packets: IDLE is always visited for at least one cycle between packets.
- request_vector_dout is always one-hot or zero. It is never nonzero in IDLE or ROUTE.
- Changes to port_status_din after ROUTE are ignored until the next packet.
- A valid_channels_din value with multiple bits set is legal; round-robin selection applies.

Test Plan:
- Single packet, PKT_FLITS = 5, FIFO pre-filled:
  - Stimulus: valid = 4'b0100, status = 4'b1111, grant tied high.
  - Required: request = 4'b0100 in cycle 2; pops in cycles 3–7; request = 0 and IDLE in cycle 8; rr_ptr = 3.
- Round-robin between packets:
  - Stimulus: valid = 4'b1111, status = 4'b1111, three packets.
  - Required: requests 4'b0001, 4'b0010, 4'b0100 in that order.
- Stall then release:
  - Stimulus: valid = 4'b0010, status = 4'b1101 for 4 cycles, then status = 4'b1111.
  - Required: route_stall_dout high for exactly 4 cycles; then request = 4'b0010.
- Grant withdrawal and FIFO underflow mid-packet:
  - Stimulus: drop grant for 2 cycles after the 2nd pop; make the FIFO empty for 1 cycle after the 4th pop.
  - Required: exactly 5 pops total; no pop while grant = 0 or fifo_empty = 1; request held throughout.
- Reset mid-XFER:
  - Stimulus: assert reset after 3 pops.
  - Required: next cycle request = 0, fifo_read = 0, state IDLE, rr_ptr = 0.
  - After reset is released with the FIFO non-empty: a new request appears 2 cycles later.
- Invariant checks throughout:
  - request_vector_dout is one-hot or zero.
  - pop count equals PKT_FLITS per granted packet.
